// File: rtl/usb_sie_pkg.sv
// rtl/usb_sie_pkg.sv - shared types, constants and helpers for the USB SIE CRC engine
//
// Holds the CRC engine state enum, the USB CRC5/CRC16 polynomial and residue
// constants, and a helper that reflects a normal-form polynomial into the
// LSB-first form used by the serial LFSR.
package usb_sie_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    EMIT  = 2'd2
  } crc_state_e;

  localparam logic [4:0]  CRC5_POLY     = 5'h05;
  localparam logic [4:0]  CRC5_RESIDUE  = 5'h06;
  localparam logic [15:0] CRC16_POLY    = 16'h8005;
  localparam logic [15:0] CRC16_RESIDUE = 16'hB001;

  // Reverse the low 'width' bits of poly; bits above width come back as zero.
  function automatic logic [15:0] reflect_poly(input logic [15:0] poly, input int width);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      if (i < width) r[width-1-i] = poly[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/usb_crc_engine_if.sv
// rtl/usb_crc_engine_if.sv - serial bit/CRC handshake bundle of the USB CRC engine
//
// master: packet side (drives start/mode/bits and the downstream crc_ready).
// slave : the CRC engine.
//   start, mode_chk          packet control
//   bit_in/bit_valid/bit_last  serial payload, LSB-first
//   crc_out/crc_valid/crc_ready serial CRC stream towards the bit-stuffer
//   crc_value, busy, done, crc_ok  status
interface usb_crc_engine_if #(
  parameter int CRC_W = 5
);
  logic             start;
  logic             mode_chk;
  logic             bit_in;
  logic             bit_valid;
  logic             bit_last;
  logic             crc_out;
  logic             crc_valid;
  logic             crc_ready;
  logic [CRC_W-1:0] crc_value;
  logic             busy;
  logic             done;
  logic             crc_ok;

  modport master (
    output start, mode_chk, bit_in, bit_valid, bit_last, crc_ready,
    input  crc_out, crc_valid, crc_value, busy, done, crc_ok
  );

  modport slave (
    input  start, mode_chk, bit_in, bit_valid, bit_last, crc_ready,
    output crc_out, crc_valid, crc_value, busy, done, crc_ok
  );

endinterface

// File: rtl/usb_crc_lfsr.sv
// rtl/usb_crc_lfsr.sv - combinational single-bit step of a reflected CRC LFSR
//
// Ports:
//   lfsr_cur  in   CRC_W  current register value
//   bit_in    in   1      serial data bit
//   lfsr_nxt  out  CRC_W  register value after absorbing bit_in
module usb_crc_lfsr
  import usb_sie_pkg::*;
#(
  parameter int               CRC_W = 5,
  parameter logic [CRC_W-1:0] POLY  = CRC5_POLY
) (
  input  logic [CRC_W-1:0] lfsr_cur,
  input  logic             bit_in,
  output logic [CRC_W-1:0] lfsr_nxt
);

  localparam logic [15:0]      POLYR_FULL = reflect_poly(16'(POLY), CRC_W);
  localparam logic [CRC_W-1:0] POLYR      = POLYR_FULL[CRC_W-1:0];

  logic fb;

  // Reflected form: the register shifts toward bit 0, so the polynomial is reversed.
  assign fb       = lfsr_cur[0] ^ bit_in;
  assign lfsr_nxt = (lfsr_cur >> 1) ^ (fb ? POLYR : '0);

endmodule

// File: rtl/usb_crc_engine.sv
// rtl/usb_crc_engine.sv - serial USB CRC5/CRC16 generate/check engine
//
// TX: absorbs packet bits LSB-first, then streams ~CRC out bit 0 first under
//     crc_valid/crc_ready. RX: absorbs payload plus received CRC and compares
//     the register with the good-packet residue.
// Ports:
//   clk   in  clock, posedge
//   rst   in  asynchronous active-low reset
//   bus   slave modport of usb_crc_engine_if (start, mode_chk, bit_*, crc_*,
//         busy, done, crc_ok)
// Build option: USB_CRC_CHECK_EN enables the RX residue check; without it
//   mode_chk is ignored (always TX) and crc_ok is constant 0.
module usb_crc_engine
  import usb_sie_pkg::*;
#(
  parameter int               CRC_W   = 5,
  parameter logic [CRC_W-1:0] POLY    = CRC5_POLY,
  parameter logic [CRC_W-1:0] RESIDUE = CRC5_RESIDUE
) (
  input  logic             clk,
  input  logic             rst,
  usb_crc_engine_if.slave  bus
);

  localparam int               CNT_W    = $clog2(CRC_W);
  localparam logic [CRC_W-1:0] INIT     = '1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CRC_W - 1);

  crc_state_e       state_q, state_d;
  logic [CRC_W-1:0] lfsr_q, lfsr_base, lfsr_step;
  logic [CRC_W-1:0] crc_value_q;
  logic [CNT_W-1:0] count_q;
  logic             mode_q, mode_eff, mode_cur;
  logic             done_q, crc_ok_q;
  logic             bit_take, last_take, emit_hs, residue_hit;

`ifdef USB_CRC_CHECK_EN
  assign mode_eff    = bus.mode_chk;
  assign residue_hit = (lfsr_step == RESIDUE);
`else
  assign mode_eff    = 1'b0;
  assign residue_hit = 1'b0;
`endif

  // start restarts from INIT in the same cycle, so a bit presented with it
  // is absorbed into the fresh packet rather than the aborted one.
  assign lfsr_base = bus.start ? INIT : lfsr_q;
  assign mode_cur  = bus.start ? mode_eff : mode_q;
  assign bit_take  = bus.bit_valid & (bus.start | (state_q == ACCUM));
  assign last_take = bit_take & bus.bit_last;
  assign emit_hs   = (state_q == EMIT) & bus.crc_ready;

  usb_crc_lfsr #(
    .CRC_W (CRC_W),
    .POLY  (POLY)
  ) u_lfsr (
    .lfsr_cur (lfsr_base),
    .bit_in   (bus.bit_in),
    .lfsr_nxt (lfsr_step)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (bus.start) begin
      if (last_take) state_d = mode_cur ? IDLE : EMIT;
      else           state_d = ACCUM;
    end else begin
      case (state_q)
        IDLE:    state_d = IDLE;
        ACCUM:   if (last_take) state_d = mode_cur ? IDLE : EMIT;
        EMIT:    if (emit_hs && (count_q == LAST_CNT)) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs
  always_comb begin
    bus.busy      = (state_q != IDLE);
    bus.crc_valid = (state_q == EMIT);
    bus.crc_out   = (state_q == EMIT) ? crc_value_q[count_q] : 1'b0;
    bus.crc_value = crc_value_q;
    bus.done      = done_q;
    bus.crc_ok    = crc_ok_q;
  end

  // Datapath: LFSR, emit counter, latched result and status pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_q      <= INIT;
      count_q     <= '0;
      crc_value_q <= '0;
      mode_q      <= 1'b0;
      done_q      <= 1'b0;
      crc_ok_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.start) begin
        mode_q   <= mode_eff;
        crc_ok_q <= 1'b0;
        count_q  <= '0;
      end
      if (bit_take)       lfsr_q <= lfsr_step;
      else if (bus.start) lfsr_q <= INIT;

      if (last_take) begin
        crc_value_q <= ~lfsr_step;
        count_q     <= '0;
        if (mode_cur) begin
          done_q   <= 1'b1;
          crc_ok_q <= residue_hit;
        end
      end else if (emit_hs && !bus.start) begin
        // An abort on the final handshake wins: no done for the dropped packet.
        if (count_q == LAST_CNT) done_q  <= 1'b1;
        else                     count_q <= count_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_usb_crc_engine.sv
// tb/tb_usb_crc_engine.sv - self-checking bench for usb_crc_engine (CRC5 and CRC16 lanes)
module tb_usb_crc_engine;
  import usb_sie_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic start = 0, mode_chk = 0, bit_in = 0, bit_valid = 0, bit_last = 0, crc_ready = 0;

  usb_crc_engine_if #(.CRC_W(5))  if5();
  usb_crc_engine_if #(.CRC_W(16)) if16();

  assign if5.start = start;      assign if16.start = start;
  assign if5.mode_chk = mode_chk; assign if16.mode_chk = mode_chk;
  assign if5.bit_in = bit_in;    assign if16.bit_in = bit_in;
  assign if5.bit_valid = bit_valid; assign if16.bit_valid = bit_valid;
  assign if5.bit_last = bit_last; assign if16.bit_last = bit_last;
  assign if5.crc_ready = crc_ready; assign if16.crc_ready = crc_ready;

  usb_crc_engine #(.CRC_W(5), .POLY(CRC5_POLY), .RESIDUE(CRC5_RESIDUE))
    dut5 (.clk(clk), .rst(rst), .bus(if5));
  usb_crc_engine #(.CRC_W(16), .POLY(CRC16_POLY), .RESIDUE(CRC16_RESIDUE))
    dut16 (.clk(clk), .rst(rst), .bus(if16));

  logic [15:0] d_val[2];
  logic d_busy[2], d_valid[2], d_out[2], d_done[2], d_ok[2];
  assign d_val[0] = {11'd0, if5.crc_value}; assign d_val[1] = if16.crc_value;
  assign d_busy[0] = if5.busy;   assign d_busy[1] = if16.busy;
  assign d_valid[0] = if5.crc_valid; assign d_valid[1] = if16.crc_valid;
  assign d_out[0] = if5.crc_out; assign d_out[1] = if16.crc_out;
  assign d_done[0] = if5.done;   assign d_done[1] = if16.done;
  assign d_ok[0] = if5.crc_ok;   assign d_ok[1] = if16.crc_ok;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lane_w(input int l);
    return (l == 0) ? 5 : 16;
  endfunction

  // Plain bitwise reflected CRC over a whole bit list: returns the raw register.
  function automatic logic [15:0] crc_raw(input int w, input bit bits[$]);
    logic [15:0] r, polyr;
    r     = (w == 16) ? 16'hFFFF : 16'h001F;
    polyr = (w == 16) ? 16'hA001 : 16'h0014;
    foreach (bits[i]) r = (r[0] ^ bits[i]) ? ((r >> 1) ^ polyr) : (r >> 1);
    return r;
  endfunction

  // ---------------- behavioural model ----------------
  bit          q_bits[$];
  int          m_phase[2];  // 0 idle, 1 collecting, 2 sending CRC
  int          m_idx[2];
  logic [15:0] m_crc[2];
  bit          m_mode[2], m_done[2], m_ok[2];

  initial begin
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        q_bits.delete();
        for (int l = 0; l < 2; l++) begin
          m_phase[l] = 0; m_idx[l] = 0; m_crc[l] = '0;
          m_mode[l] = 0; m_done[l] = 0; m_ok[l] = 0;
        end
      end else begin
        bit acc;
        acc = bit_valid && (start || m_phase[0] == 1 || m_phase[1] == 1);
        if (start) q_bits.delete();
        if (acc) q_bits.push_back(bit_in);
        for (int l = 0; l < 2; l++) begin
          logic [15:0] raw, mask, res;
          mask = (l == 0) ? 16'h001F : 16'hFFFF;
          res  = (l == 0) ? 16'h0006 : 16'hB001;
          m_done[l] = 0;
          if (start) begin
`ifdef USB_CRC_CHECK_EN
            m_mode[l] = mode_chk;
`else
            m_mode[l] = 0;
`endif
            m_ok[l] = 0;
          end
          if (acc && bit_last) begin
            raw = crc_raw(lane_w(l), q_bits);
            m_crc[l] = ~raw & mask;
            if (m_mode[l]) begin
              m_phase[l] = 0; m_done[l] = 1; m_ok[l] = (raw == res);
            end else begin
              m_phase[l] = 2; m_idx[l] = 0;
            end
          end else if (start) begin
            m_phase[l] = 1;
          end else if (m_phase[l] == 2 && crc_ready) begin
            if (m_idx[l] == lane_w(l) - 1) begin m_phase[l] = 0; m_done[l] = 1; end
            else m_idx[l]++;
          end
        end
      end
    end
  end

  // ---------------- compare process + capture ----------------
  bit          cap[2][$];
  int          done_cnt[2];
  bit          done_ok[2];

  initial begin
    forever begin
      @(negedge clk);
      for (int l = 0; l < 2; l++) begin
        logic exp_out;
        exp_out = (m_phase[l] == 2) ? m_crc[l][m_idx[l]] : 1'b0;
        chk($sformatf("busy[%0d]", l), 16'(d_busy[l]), 16'(m_phase[l] != 0));
        chk($sformatf("crc_valid[%0d]", l), 16'(d_valid[l]), 16'(m_phase[l] == 2));
        chk($sformatf("crc_out[%0d]", l), 16'(d_out[l]), 16'(exp_out));
        chk($sformatf("done[%0d]", l), 16'(d_done[l]), 16'(m_done[l]));
        chk($sformatf("crc_ok[%0d]", l), 16'(d_ok[l]), 16'(m_ok[l]));
        chk($sformatf("crc_value[%0d]", l), d_val[l], m_crc[l]);
        if (d_valid[l] && crc_ready) cap[l].push_back(d_out[l]);
        if (d_done[l]) begin done_cnt[l]++; done_ok[l] = d_ok[l]; end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  int cyc = 0;
  int policy = 0;  // 0 always ready, 1 toggle, 2 random

  task automatic step();
    case (policy)
      0: crc_ready = 1'b1;
      1: crc_ready = cyc[0];
      default: crc_ready = 1'($urandom_range(0, 1));
    endcase
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic clear_caps();
    for (int l = 0; l < 2; l++) begin cap[l].delete(); done_cnt[l] = 0; done_ok[l] = 0; end
  endtask

  task automatic send(input bit bits[$], input bit mode, input bit with_last, input bit gaps);
    for (int i = 0; i < bits.size(); i++) begin
      if (gaps && i > 0 && $urandom_range(0, 3) == 0) begin
        bit_valid = 0; bit_in = 1'($urandom); bit_last = 1'($urandom); start = 0;
        step();
      end
      start     = (i == 0);
      mode_chk  = (i == 0) ? mode : 1'($urandom);
      bit_valid = 1;
      bit_in    = bits[i];
      bit_last  = with_last && (i == bits.size() - 1);
      step();
    end
    start = 0; bit_valid = 0; bit_last = 0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((d_busy[0] || d_busy[1]) && n < 300) begin
      bit_valid = 1'($urandom); bit_in = 1'($urandom); bit_last = 1'($urandom);
      step();
      n++;
    end
    bit_valid = 0; bit_last = 0;
    if (n >= 300) chk("idle_timeout", 16'd1, 16'd0);
    @(negedge clk); #1;
  endtask

  function automatic void add_byte(inout bit q[$], input logic [7:0] b);
    for (int i = 0; i < 8; i++) q.push_back(b[i]);
  endfunction

  function automatic void add_str(inout bit q[$]);
    string s;
    s = "123456789";
    for (int i = 0; i < s.len(); i++) add_byte(q, s[i]);
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    bit pkt[$];
    bit rx[$];
    logic [15:0] v;

    rst = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy5", 16'(if5.busy), 16'd0);
    chk("reset_val16", if16.crc_value, 16'd0);
    rst = 1;
    step();

    // model pins
    add_str(pkt);
    chk("ref_crc5", ~crc_raw(5, pkt) & 16'h1F, 16'h0019);
    chk("ref_crc16", ~crc_raw(16, pkt), 16'hB4C8);

    // 1/2: TX of "123456789"
    clear_caps(); policy = 0;
    send(pkt, 0, 1, 0);
    chk("lat_first_valid5", 16'(if5.crc_valid), 16'd1);
    wait_idle();
    chk("tx_crc5", d_val[0], 16'h0019);
    chk("tx_crc16", d_val[1], 16'hB4C8);
    chk("tx5_nbits", 16'(cap[0].size()), 16'd5);
    for (int i = 0; i < 5 && i < cap[0].size(); i++)
      chk($sformatf("tx5_bit%0d", i), 16'(cap[0][i]), 16'(i == 0 || i == 3 || i == 4));
    v = '0;
    for (int i = 0; i < 16 && i < cap[1].size(); i++) v[i] = cap[1][i];
    chk("tx16_serial", v, 16'hB4C8);
    chk("tx_done_cnt5", 16'(done_cnt[0]), 16'd1);
    chk("tx_done_cnt16", 16'(done_cnt[1]), 16'd1);

    // 3: RX good and RX with one flipped bit
    rx = pkt; add_byte(rx, 8'hC8); add_byte(rx, 8'hB4);
    clear_caps(); policy = 0;
    send(rx, 1, 1, 1);
    wait_idle();
`ifdef USB_CRC_CHECK_EN
    chk("rx_good_ok16", 16'(done_ok[1]), 16'd1);
`else
    chk("rx_good_ok16", 16'(done_ok[1]), 16'd0);
    chk("rx_as_tx_bits16", 16'(cap[1].size()), 16'd16);
`endif
    chk("rx_done_cnt16", 16'(done_cnt[1]), 16'd1);
    for (int k = 0; k < 3; k++) begin
      bit bad_rx[$];
      int pos;
      bad_rx = rx;
      pos = $urandom_range(0, bad_rx.size() - 1);
      bad_rx[pos] = ~bad_rx[pos];
      clear_caps();
      send(bad_rx, 1, 1, 0);
      wait_idle();
      chk($sformatf("rx_flip_ok16_%0d", k), 16'(done_ok[1]), 16'd0);
    end

    // 4: stalled emit with crc_ready toggling
    clear_caps(); policy = 1;
    send(pkt, 0, 1, 0);
    wait_idle();
    chk("stall_hs5", 16'(cap[0].size()), 16'd5);
    chk("stall_done5", 16'(done_cnt[0]), 16'd1);
    chk("stall_crc5", d_val[0], 16'h0019);

    // 5: abort after 20 bits, then a clean packet
    begin
      bit junk[$];
      for (int i = 0; i < 20; i++) junk.push_back(1'($urandom));
      policy = 0;
      send(junk, 0, 0, 0);
    end
    clear_caps();
    send(pkt, 0, 1, 0);
    wait_idle();
    chk("abort_crc5", d_val[0], 16'h0019);
    chk("abort_crc16", d_val[1], 16'hB4C8);

    // reset in the middle of EMIT
    send(pkt, 0, 1, 0);
    crc_ready = 0;
    #2 rst = 0;
    #1;
    chk("rst_busy5", 16'(if5.busy), 16'd0);
    chk("rst_valid16", 16'(if16.crc_valid), 16'd0);
    chk("rst_val16", if16.crc_value, 16'd0);
    chk("rst_done5", 16'(if5.done), 16'd0);
    #3 rst = 1;
    @(posedge clk); #1;

    // zero-length boundary: start together with bit_valid&bit_last
    begin
      bit one[$];
      one.push_back(1'b1);
      clear_caps(); policy = 0;
      send(one, 0, 1, 0);
      chk("zlen_valid5", 16'(if5.crc_valid), 16'd1);
      wait_idle();
      chk("zlen_done5", 16'(done_cnt[0]), 16'd1);
    end

    // randomized packets
    for (int n = 0; n < 40; n++) begin
      bit rp[$];
      int len;
      len = $urandom_range(1, 48);
      for (int i = 0; i < len; i++) rp.push_back(1'($urandom));
      policy = $urandom_range(0, 2);
      send(rp, 1'($urandom), ($urandom_range(0, 5) != 0), 1);
      if ($urandom_range(0, 3) == 0) begin
        // start lands on an arbitrary phase of the previous packet
        rp.delete();
        for (int i = 0; i < 12; i++) rp.push_back(1'($urandom));
        send(rp, 1'($urandom), 1, 1);
      end
      wait_idle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
